iir_output_decimator: RTL and testbench

//   Reader side of the biquad's sample output. Takes the filter's output stream (one signed

---
 rtl/iir_pkg.sv | 18 +
 rtl/iir_output_decimator_fifo.sv | 88 ++++++++
 rtl/iir_output_decimator.sv | 108 ++++++++++
 tb/tb_iir_output_decimator.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Types and helpers shared by the biquad datapath and its output decimator.
package iir_pkg;

    localparam int IIR_DATA_W = 16;

    typedef logic signed [IIR_DATA_W-1:0] iir_sample_t;

    // Ceiling log2, usable in parameter expressions; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/iir_output_decimator_fifo.sv
// First-word-fall-through synchronous FIFO. The head sits in a register, so rd_data
// keeps showing the last sample read while the FIFO is empty.
module sync_fifo_fwft
    import iir_pkg::*;
#(
    parameter int DATA_W = IIR_DATA_W,
    parameter int DEPTH  = 8,
    localparam int AW    = clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic [LW-1:0]     level
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic [LW-1:0]     w_level_next;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] w_head_next;
    logic              w_rd;
    logic              w_wr;

    assign full    = (r_level == LW'(DEPTH));
    assign empty   = (r_level == LW'(0));
    assign w_rd    = rd_en && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign w_wr    = wr_en && (!full || w_rd);
    assign rd_data = r_head;
    assign level   = r_level;

    // Occupancy after this edge.
    always_comb begin
        w_level_next = r_level;
        case ({w_wr, w_rd})
            2'b10:   w_level_next = r_level + LW'(1);
            2'b01:   w_level_next = r_level - LW'(1);
            default: w_level_next = r_level;
        endcase
    end

    // Next head: the incoming word if it lands in an otherwise empty queue, else the next entry.
    always_comb begin
        w_head_next = r_head;
        if (w_wr && ((r_level - LW'(w_rd)) == LW'(0))) begin
            w_head_next = wr_data;
        end else if (w_rd && (w_level_next != LW'(0))) begin
            w_head_next = r_mem[r_rd_ptr + AW'(1)];
        end else begin
            w_head_next = r_head;
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and head register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_level  <= LW'(0);
            r_head   <= DATA_W'(0);
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= w_level_next;
            r_head  <= w_head_next;
        end
    end

endmodule

// File: rtl/iir_output_decimator.sv
// Decimates the biquad output stream by DECIM and queues results for a valid/ready consumer.
// Define IIR_DECIM_AVG_EN to output the boxcar mean of each window instead of its last sample.
module iir_output_decimator
    import iir_pkg::*;
#(
    parameter int DATA_W     = IIR_DATA_W,
    parameter int DECIM      = 8,
    parameter int FIFO_DEPTH = 8,
    localparam int LVL_W     = clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     overflow,
    output logic [LVL_W-1:0]         fifo_level
);

    localparam int PH_W = clog2(DECIM);

    logic [PH_W-1:0]          r_phase;
    logic                     w_last;
    logic signed [DATA_W-1:0] w_dec_next;
    logic signed [DATA_W-1:0] r_dec;
    logic                     r_dec_vld;
    logic                     r_overflow;
    logic                     w_drop;
    logic                     w_full;
    logic                     w_empty;
    logic [DATA_W-1:0]        w_rd_data;
    logic [LVL_W-1:0]         w_level;

    assign w_last = (r_phase == PH_W'(DECIM - 1));

`ifdef IIR_DECIM_AVG_EN
    localparam int ACC_W = DATA_W + PH_W;

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_din_ext;
    logic signed [ACC_W-1:0] w_sum;

    assign w_din_ext  = ACC_W'(din);
    assign w_sum      = (r_phase == PH_W'(0)) ? w_din_ext : (r_acc + w_din_ext);
    // Arithmetic shift floors, so negative means round toward minus infinity.
    assign w_dec_next = DATA_W'(w_sum >>> PH_W);

    // Window accumulator, reloaded at phase 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= ACC_W'(0);
        end else begin
            r_acc <= w_sum;
        end
    end
`else
    assign w_dec_next = din;
`endif

    // Phase counter and decimated-sample register; the FIFO write follows one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase   <= PH_W'(0);
            r_dec     <= DATA_W'(0);
            r_dec_vld <= 1'b0;
        end else begin
            r_phase   <= r_phase + PH_W'(1);
            r_dec_vld <= w_last;
            if (w_last) begin
                r_dec <= w_dec_next;
            end
        end
    end

    // A pending sample is lost only if the FIFO is full and the head is not leaving.
    assign w_drop = r_dec_vld && w_full && !m_tready;

    // Sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow | w_drop;
        end
    end

    sync_fifo_fwft #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (r_dec_vld),
        .wr_data (r_dec),
        .full    (w_full),
        .rd_en   (m_tready),
        .rd_data (w_rd_data),
        .empty   (w_empty),
        .level   (w_level)
    );

    assign m_tdata    = w_rd_data;
    assign m_tvalid   = !w_empty;
    assign overflow   = r_overflow;
    assign fifo_level = w_level;

endmodule

// File: tb/tb_iir_output_decimator.sv
// Self-checking bench for iir_output_decimator against a queue-based behavioural model.
module tb_iir_output_decimator;

    localparam int DW  = 16;
    localparam int DEC = 8;
    localparam int DEP = 8;
    localparam int LW  = 4;
`ifdef IIR_DECIM_AVG_EN
    localparam int OFS = 3;
`else
    localparam int OFS = 7;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] din;
    logic signed [DW-1:0] m_tdata;
    logic                 m_tvalid;
    logic                 m_tready;
    logic                 overflow;
    logic [LW-1:0]        fifo_level;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int mq[$];
    int popped[$];
    int win[DEC];
    int m_last;
    bit m_ovf;
    int m_n;
    bit pend_v;
    int pend_d;
    bit chk_en = 1'b0;
    bit prev_v = 1'b0;
    int prev_d = 0;

    always #5 clk = ~clk;

    iir_output_decimator #(
        .DATA_W     (DW),
        .DECIM      (DEC),
        .FIFO_DEPTH (DEP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decim_value();
`ifdef IIR_DECIM_AVG_EN
        int s;
        int q;
        s = 0;
        for (int k = 0; k < DEC; k++) s += win[k];
        q = s / DEC;
        if ((s % DEC) != 0 && s < 0) q = q - 1;
        return q;
`else
        return win[DEC-1];
`endif
    endfunction

    function automatic int exp_head();
        return (mq.size() > 0) ? mq[0] : m_last;
    endfunction

    // One clock edge of the model, fed with the inputs the DUT saw at that edge.
    task automatic model_step();
        bit rd;
        if (rst) begin
            mq.delete();
            m_last = 0;
            m_ovf  = 1'b0;
            m_n    = 0;
            pend_v = 1'b0;
        end else begin
            rd = m_tready && (mq.size() > 0);
            if (rd) begin
                m_last = mq.pop_front();
                popped.push_back(m_last);
            end
            if (pend_v) begin
                if (mq.size() < DEP) mq.push_back(pend_d);
                else m_ovf = 1'b1;
            end
            win[m_n % DEC] = int'(din);
            pend_v = ((m_n % DEC) == DEC - 1);
            if (pend_v) pend_d = decim_value();
            m_n++;
        end
    endtask

    task automatic cyc(input int d, input bit r, input bit rdy);
        din      = DW'(d);
        rst      = r;
        m_tready = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    // Compare DUT outputs against the model every cycle, plus stall stability.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_tvalid", int'(m_tvalid), int'(mq.size() > 0));
            chk("m_tdata", int'(m_tdata), exp_head());
            chk("fifo_level", int'(fifo_level), mq.size());
            chk("overflow", int'(overflow), int'(m_ovf));
            if (prev_v && !m_tready && !rst) begin
                chk("stall_data", int'(m_tdata), prev_d);
                chk("stall_valid", int'(m_tvalid), 1);
            end
            prev_v <= m_tvalid;
            prev_d <= int'(m_tdata);
        end
    end

    initial begin
        rst = 1'b1; din = '0; m_tready = 1'b0;
        cyc(0, 1'b1, 1'b0);
        cyc(0, 1'b1, 1'b0);
        chk_en = 1'b1;
        chk("reset_tvalid", int'(m_tvalid), 0);
        chk("reset_tdata", int'(m_tdata), 0);
        chk("reset_level", int'(fifo_level), 0);
        chk("reset_overflow", int'(overflow), 0);

        // Ramp with ready held high
        popped.delete();
        for (int i = 0; i < 40; i++) begin
            cyc(i, 1'b0, 1'b1);
            if (i == 7) chk("latency_not_yet", int'(m_tvalid), 0);
            if (i == 8) begin
                chk("latency_valid", int'(m_tvalid), 1);
                chk("latency_data", int'(m_tdata), OFS);
            end
        end
        for (int k = 0; k < 4; k++) chk("ramp_out", popped[k], 8 * k + OFS);

        // Constant inputs, including the most negative sample
        cyc(0, 1'b1, 1'b1);
        popped.delete();
        for (int i = 0; i < 20; i++) cyc(-32768, 1'b0, 1'b1);
        chk("const_min_model", popped[0], -32768);
        cyc(0, 1'b1, 1'b1);
        popped.delete();
        for (int i = 0; i < 20; i++) cyc(-5, 1'b0, 1'b1);
        chk("const_m5_model", popped[0], -5);
        chk("const_m5_dut", int'(m_tdata), -5);

        // Overflow: no reads for 80 cycles, then drain
        cyc(0, 1'b1, 1'b0);
        popped.delete();
        for (int i = 0; i < 80; i++) cyc(i, 1'b0, 1'b0);
        chk("ovf_level", int'(fifo_level), 8);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_model", int'(m_ovf), 1);
        for (int i = 80; i < 160; i++) cyc(i, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) chk("ovf_drain", popped[k], 8 * k + OFS);
        chk("ovf_sticky", int'(overflow), 1);

        // Full boundary: simultaneous read and write at level 8
        cyc(0, 1'b1, 1'b0);
        for (int i = 0; i <= 72; i++) cyc(i, 1'b0, (i == 72));
        chk("full_level", int'(fifo_level), 8);
        chk("full_overflow", int'(overflow), 0);
        chk("full_head", int'(m_tdata), 8 + OFS);

        // Random data with random backpressure, then drain
        cyc(0, 1'b1, 1'b0);
        for (int i = 0; i < 200; i++)
            cyc(int'($urandom_range(65535, 0)) - 32768, 1'b0, bit'($urandom_range(1, 0)));
        for (int i = 0; i < 80; i++) cyc(int'($urandom_range(65535, 0)) - 32768, 1'b0, 1'b1);

        // Reset mid-stream with 3 queued samples at phase 4
        cyc(0, 1'b1, 1'b0);
        for (int i = 0; i < 28; i++) cyc(i, 1'b0, 1'b0);
        chk("mid_level", int'(fifo_level), 3);
        chk("mid_phase_model", m_n % DEC, 4);
        cyc(0, 1'b1, 1'b0);
        chk("mid_rst_valid", int'(m_tvalid), 0);
        chk("mid_rst_level", int'(fifo_level), 0);
        chk("mid_rst_overflow", int'(overflow), 0);
        popped.delete();
        for (int i = 0; i < 16; i++) cyc(i, 1'b0, 1'b1);
        chk("mid_restart_first", popped[0], OFS);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
